// File: rtl/mp64_extmem_bridge_if.sv
`default_nettype none
// mp64_extmem_bridge_if: upstream ext_* request port plus downstream xb_* beat bus.
interface mp64_extmem_bridge_if;
  logic        ext_req;
  logic [63:0] ext_addr;
  logic [63:0] ext_wdata;
  logic        ext_wen;
  logic [1:0]  ext_size;
  logic [63:0] ext_rdata;
  logic        ext_ack;
  logic        xb_valid;
  logic        xb_ready;
  logic [63:0] xb_addr;
  logic        xb_wen;
  logic [3:0]  xb_wstrb;
  logic [31:0] xb_wdata;
  logic        xb_rvalid;
  logic [31:0] xb_rdata;

  // slave is the bridge's view; master is the surrounding system (CPU side plus device side).
  modport slave (
    input  ext_req, ext_addr, ext_wdata, ext_wen, ext_size, xb_ready, xb_rvalid, xb_rdata,
    output ext_rdata, ext_ack, xb_valid, xb_addr, xb_wen, xb_wstrb, xb_wdata
  );
  modport master (
    output ext_req, ext_addr, ext_wdata, ext_wen, ext_size, xb_ready, xb_rvalid, xb_rdata,
    input  ext_rdata, ext_ack, xb_valid, xb_addr, xb_wen, xb_wstrb, xb_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mp64_extmem_bridge.sv
`default_nettype none
// mp64_extmem_bridge: splits 64-bit ext requests into 32-bit xb beats with per-transaction timeout.
module mp64_extmem_bridge #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mp64_extmem_bridge_if.slave  bus,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam logic [1:0]  BUS_BYTE  = 2'd0;
  localparam logic [1:0]  BUS_HALF  = 2'd1;
  localparam logic [1:0]  BUS_WORD  = 2'd2;
  localparam logic [1:0]  BUS_DWORD = 2'd3;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  function automatic beat_t plan_beat(input logic [63:0] a, input logic [63:0] d,
                                      input logic w, input logic [1:0] sz, input logic b);
    beat_t p;
    p.addr = {a[63:2], 2'b00};
    p.strb = 4'hF;
    p.data = d[31:0];
    case (sz)
      BUS_DWORD: begin
        p.addr = {a[63:3], b, 2'b00};
        p.data = b ? d[63:32] : d[31:0];
      end
      BUS_HALF: begin
        p.strb = a[1] ? 4'b1100 : 4'b0011;
        p.data = {2{d[15:0]}};
      end
      BUS_BYTE: begin
        p.strb = 4'b0001 << a[1:0];
        p.data = {4{d[7:0]}};
      end
      default: ;
    endcase
    if (!w) p.strb = 4'hF;
    return p;
  endfunction

  function automatic logic [63:0] extract(input logic [31:0] r, input logic [31:0] lo,
                                          input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      BUS_DWORD: return {r, lo};
      BUS_WORD:  return {32'h0, r};
      BUS_HALF:  return {48'h0, (a[1] ? r[31:16] : r[15:0])};
      default:   return {56'h0, r[{a, 3'b000} +: 8]};
    endcase
  endfunction

  state_t      state;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        wen_q;
  logic [1:0]  size_q;
  logic        beat_q;
  logic [15:0] cnt_q;
  logic [31:0] rlo_q;

  beat_t plan_first;
  beat_t plan_second;
  assign plan_first  = plan_beat(bus.ext_addr, bus.ext_wdata, bus.ext_wen, bus.ext_size, 1'b0);
  assign plan_second = plan_beat(addr_q, wdata_q, wen_q, size_q, 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      size_q        <= '0;
      beat_q        <= 1'b0;
      cnt_q         <= '0;
      rlo_q         <= '0;
      bus.ext_rdata <= '0;
      bus.ext_ack   <= 1'b0;
      bus.xb_valid  <= 1'b0;
      bus.xb_addr   <= '0;
      bus.xb_wen    <= 1'b0;
      bus.xb_wstrb  <= '0;
      bus.xb_wdata  <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      bus.ext_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ext_req) begin
            addr_q       <= bus.ext_addr;
            wdata_q      <= bus.ext_wdata;
            wen_q        <= bus.ext_wen;
            size_q       <= bus.ext_size;
            beat_q       <= 1'b0;
            cnt_q        <= '0;
            bus.xb_valid <= 1'b1;
            bus.xb_addr  <= plan_first.addr;
            bus.xb_wstrb <= plan_first.strb;
            bus.xb_wdata <= plan_first.data;
            bus.xb_wen   <= bus.ext_wen;
            busy         <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR, RESP: begin
          // The timeout wins over any handshake landing in the same cycle.
          if (cnt_q == TO_LAST) begin
            bus.xb_valid <= 1'b0;
            err_timeout  <= 1'b1;
            bus.ext_ack  <= 1'b1;
            if (!wen_q) bus.ext_rdata <= '1;
            state        <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (state == ADDR) begin
              if (bus.xb_ready) begin
                bus.xb_valid <= 1'b0;
                state        <= RESP;
              end
            end else if (bus.xb_rvalid) begin
              if (!wen_q && !beat_q) rlo_q <= bus.xb_rdata;
              if (size_q == BUS_DWORD && !beat_q) begin
                beat_q       <= 1'b1;
                bus.xb_valid <= 1'b1;
                bus.xb_addr  <= plan_second.addr;
                bus.xb_wstrb <= plan_second.strb;
                bus.xb_wdata <= plan_second.data;
                state        <= ADDR;
              end else begin
                if (!wen_q) bus.ext_rdata <= extract(bus.xb_rdata, rlo_q, addr_q[1:0], size_q);
                bus.ext_ack <= 1'b1;
                state       <= DONE;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mp64_extmem_bridge.sv
`default_nettype none
// tb_mp64_extmem_bridge: directed transactions checked against a transaction-level beat/data model.
module tb_mp64_extmem_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err_timeout;

  mp64_extmem_bridge_if bus();

  mp64_extmem_bridge #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_cnt = 0;

  logic        tx_active = 1'b0;
  logic [63:0] tx_addr, tx_wdata, tx_exp_rdata;
  logic        tx_wen;
  logic [1:0]  tx_size;
  int          drv_beat = 0;
  logic [63:0] beat_addr [2];
  logic [3:0]  last_strb;
  logic [31:0] last_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_addr(input logic [63:0] a, input logic [1:0] sz, input int b);
    if (sz == 2'd3) return (a & ~64'h7) + 64'(4 * b);
    return a & ~64'h3;
  endfunction

  function automatic logic [3:0] m_strb(input logic [63:0] a, input logic [1:0] sz, input logic w);
    if (!w || sz >= 2'd2) return 4'hF;
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [63:0] d, input logic [1:0] sz, input int b);
    case (sz)
      2'd3:    return (b == 1) ? d[63:32] : d[31:0];
      2'd2:    return d[31:0];
      2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
      default: return 32'(d[7:0]) * 32'h0101_0101;
    endcase
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] a, input logic [1:0] sz,
                                          input logic [31:0] r0, input logic [31:0] r1);
    case (sz)
      2'd3:    return {r1, r0};
      2'd2:    return 64'(r0);
      2'd1:    return 64'((r0 >> (16 * ((a >> 1) % 2))) & 32'hFFFF);
      default: return 64'((r0 >> (8 * (a % 4))) & 32'hFF);
    endcase
  endfunction

  // Compare process: every cycle after the edge settles, check DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n && tx_active) begin
      if (bus.xb_valid) begin
        check("xb_addr", bus.xb_addr, m_addr(tx_addr, tx_size, drv_beat));
        check("xb_wstrb", 64'(bus.xb_wstrb), 64'(m_strb(tx_addr, tx_size, tx_wen)));
        check("xb_wen", 64'(bus.xb_wen), 64'(tx_wen));
        if (tx_wen) check("xb_wdata", 64'(bus.xb_wdata), 64'(m_wdata(tx_wdata, tx_size, drv_beat)));
        check("busy_in_beat", 64'(busy), 64'd1);
        beat_addr[drv_beat[0]] = bus.xb_addr;
        last_strb  = bus.xb_wstrb;
        last_wdata = bus.xb_wdata;
      end
      if (bus.ext_ack) begin
        ack_cnt++;
        check("busy_in_done", 64'(busy), 64'd1);
        if (!tx_wen) check("ext_rdata", bus.ext_rdata, tx_exp_rdata);
      end
    end else if (rst_n) begin
      check("idle_quiet", {61'd0, bus.xb_valid, bus.ext_ack, busy}, 64'd0);
    end
  end

  task automatic run_txn(input logic [63:0] a, input logic [63:0] d, input logic w,
                         input logic [1:0] sz, input int rdly, input int vdly,
                         input logic [31:0] r0, input logic [31:0] r1, input logic to,
                         output int lat);
    int n;
    int start;
    int acks0;
    int nb;
    nb = to ? 0 : ((sz == 2'd3) ? 2 : 1);
    tx_addr      = a;
    tx_wdata     = d;
    tx_wen       = w;
    tx_size      = sz;
    tx_exp_rdata = to ? 64'hFFFF_FFFF_FFFF_FFFF : m_rdata(a, sz, r0, r1);
    drv_beat     = 0;
    tx_active    = 1'b1;
    acks0        = ack_cnt;
    bus.ext_req   = 1'b1;
    bus.ext_addr  = a;
    bus.ext_wdata = d;
    bus.ext_wen   = w;
    bus.ext_size  = sz;
    start = cyc;
    @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      n = 0;
      while (!bus.xb_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("beat_valid", 64'(bus.xb_valid), 64'd1);
      if (rdly > 0) begin
        // A response arriving while the beat is still unaccepted must be ignored.
        bus.xb_rvalid = 1'b1;
        bus.xb_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.xb_rvalid = 1'b0;
        repeat (rdly - 1) @(negedge clk);
      end
      bus.xb_ready = 1'b1;
      @(negedge clk);
      bus.xb_ready = 1'b0;
      drv_beat = b + 1;
      repeat (vdly) @(negedge clk);
      bus.xb_rvalid = 1'b1;
      bus.xb_rdata  = (b == 1) ? r1 : r0;
      @(negedge clk);
      bus.xb_rvalid = 1'b0;
    end
    n = 0;
    while (!bus.ext_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", 64'(bus.ext_ack), 64'd1);
    lat = cyc - start;
    bus.ext_req = 1'b0;
    @(negedge clk);
    check("ack_single", 64'(bus.ext_ack), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("ack_count", 64'(ack_cnt - acks0), 64'd1);
    tx_active = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ext_ack"}, 64'(bus.ext_ack), 64'd0);
    check({tag, "_ext_rdata"}, bus.ext_rdata, 64'd0);
    check({tag, "_xb_valid"}, 64'(bus.xb_valid), 64'd0);
    check({tag, "_xb_addr"}, bus.xb_addr, 64'd0);
    check({tag, "_xb_fields"}, {27'd0, bus.xb_wen, bus.xb_wstrb, bus.xb_wdata}, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err_timeout), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks0;
    bus.ext_req   = 1'b0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;
    bus.ext_wen   = 1'b0;
    bus.ext_size  = '0;
    bus.xb_ready  = 1'b0;
    bus.xb_rvalid = 1'b0;
    bus.xb_rdata  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(64'h10_0008, 64'h0, 1'b0, 2'd3, 0, 0, 32'h1122_3344, 32'h5566_7788, 1'b0, lat);
    check("dword_rd_latency", 64'(lat), 64'd5);
    check("dword_rd_beat0", beat_addr[0], 64'h10_0008);
    check("dword_rd_beat1", beat_addr[1], 64'h10_000C);
    check("dword_rd_data", bus.ext_rdata, 64'h5566_7788_1122_3344);

    run_txn(64'h20_0003, 64'hA5, 1'b1, 2'd0, 0, 0, 32'h0, 32'h0, 1'b0, lat);
    check("byte_wr_latency", 64'(lat), 64'd3);
    check("byte_wr_addr", beat_addr[0], 64'h20_0000);
    check("byte_wr_strb", 64'(last_strb), 64'h8);
    check("byte_wr_data", 64'(last_wdata), 64'hA5A5_A5A5);
    check("rdata_hold_on_write", bus.ext_rdata, 64'h5566_7788_1122_3344);

    run_txn(64'h30_0006, 64'h0, 1'b0, 2'd1, 0, 0, 32'hBEEF_1234, 32'h0, 1'b0, lat);
    check("half_rd_data", bus.ext_rdata, 64'h0000_0000_0000_BEEF);

    run_txn(64'h50_0005, 64'hFFFF_0000_CAFE_BABE, 1'b1, 2'd2, 1, 1, 32'h0, 32'h0, 1'b0, lat);
    run_txn(64'h60_0002, 64'h0, 1'b0, 2'd0, 0, 2, 32'hAABB_CCDD, 32'h0, 1'b0, lat);
    check("byte_rd_data", bus.ext_rdata, 64'h0000_0000_0000_00BB);
    run_txn(64'h68_0005, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd3, 2, 0, 32'h0, 32'h0, 1'b0, lat);
    check("dword_wr_beat1", beat_addr[1], 64'h68_0004);

    run_txn(64'h70_0002, 64'h1357, 1'b1, 2'd1, 5, 3, 32'h0, 32'h0, 1'b0, lat);
    check("backpressure_latency", 64'(lat), 64'd11);
    check("backpressure_strb", 64'(last_strb), 64'hC);
    check("backpressure_data", 64'(last_wdata), 64'h1357_1357);

    run_txn(64'h80_0000, 64'h0, 1'b0, 2'd3, 0, 0, 32'h0, 32'h0, 1'b1, lat);
    check("timeout_latency", 64'(lat), 64'(TO + 1));
    check("timeout_rdata", bus.ext_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("timeout_err", 64'(err_timeout), 64'd1);

    run_txn(64'h90_0000, 64'h0, 1'b0, 2'd2, 0, 0, 32'hCAFE_F00D, 32'h0, 1'b0, lat);
    check("post_timeout_data", bus.ext_rdata, 64'h0000_0000_CAFE_F00D);
    check("post_timeout_err_sticky", 64'(err_timeout), 64'd1);

    // Reset during RESP of beat 0 of a dword write.
    tx_addr   = 64'hA0_0010;
    tx_wdata  = 64'h0123_4567_89AB_CDEF;
    tx_wen    = 1'b1;
    tx_size   = 2'd3;
    drv_beat  = 0;
    tx_active = 1'b1;
    acks0     = ack_cnt;
    bus.ext_req   = 1'b1;
    bus.ext_addr  = tx_addr;
    bus.ext_wdata = tx_wdata;
    bus.ext_wen   = 1'b1;
    bus.ext_size  = 2'd3;
    @(negedge clk);
    check("rst_test_valid", 64'(bus.xb_valid), 64'd1);
    bus.xb_ready = 1'b1;
    @(negedge clk);
    bus.xb_ready = 1'b0;
    drv_beat = 1;
    check("rst_test_in_resp", {62'd0, bus.xb_valid, busy}, 64'd1);
    rst_n = 1'b0;
    tx_active = 1'b0;
    bus.ext_req = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    check("midrst_no_ack", 64'(ack_cnt - acks0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(64'hB0_0000, 64'hFEDC_BA98_7654_3210, 1'b1, 2'd3, 0, 0, 32'h0, 32'h0, 1'b0, lat);
    check("post_reset_latency", 64'(lat), 64'd5);
    check("post_reset_err", 64'(err_timeout), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mp64_extmem_bridge.md
# mp64_extmem_bridge

Downstream consumer of the memory subsystem's external-memory request port (`ext_*`). It serves addresses at or above 1 MiB. Each 64-bit request (byte/half/word/dword) becomes one or two 32-bit beats on a simple valid/ready external bus (`xb_*`), with a separate response phase per beat. It reassembles the read data, returns a one-cycle `ext_ack`, and enforces a per-transaction timeout so that an absent device cannot hang the CPU.

## Interface
- `TIMEOUT_CYC`, default 1024: cycles from accept to forced completion; range 2..65535.
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ext_req`  in  1  request valid; held by upstream until it samples `ext_ack`
- `ext_addr`  in  64  byte address
- `ext_wdata`  in  64  write data, right-justified
- `ext_wen`  in  1  1=write, 0=read
- `ext_size`  in  2  size code: 0=byte, 1=half, 2=word, 3=dword (BUS_* encoding)
- `ext_rdata`  out  64  read data, zero-extended; valid while `ext_ack`=1
- `ext_ack`  out  1  one-cycle completion pulse
- `xb_valid`  out  1  beat request valid
- `xb_ready`  in  1  external bus accepts beat
- `xb_addr`  out  64  beat address, 4-byte aligned
- `xb_wen`  out  1  beat is write
- `xb_wstrb`  out  4  byte-lane enables (writes); 4'hF on reads
- `xb_wdata`  out  32  beat write data, lane-positioned
- `xb_rvalid`  in  1  beat response (read data or write completion)
- `xb_rdata`  in  32  beat read data
- `busy`  out  1  transaction in progress (any state but IDLE)
- `err_timeout`  out  1  sticky; set on any timeout; cleared only by reset

## Operation
- FSM states: IDLE, ADDR, RESP, DONE.
- IDLE: on `ext_req`=1, latch addr/wdata/wen/size, clear timeout counter, set beat index 0, go to ADDR. Nothing is latched while in other states.
- Beat plan:
  - dword: 2 beats. Beat 0 at `{addr[63:3],3'b000}` carries wdata[31:0]. Beat 1 at +4 carries wdata[63:32]. Strobes 4'hF.
  - word: 1 beat at `{addr[63:2],2'b00}`, strobe 4'hF.
  - half: 1 beat. Strobe 4'b0011 if addr[1]=0, else 4'b1100. Data duplicated to both halves.
  - byte: 1 beat. Strobe `1<<addr[1:0]`. Data replicated to all 4 lanes.
  - Misaligned low address bits beyond the access size are ignored (aligned down); no fault is raised.
- ADDR: drive `xb_valid`=1 with beat fields stable until `xb_ready`=1 is sampled, then go to RESP. `xb_valid` drops the cycle after the handshake.
- RESP: wait for `xb_rvalid`. On reads, capture `xb_rdata` into the beat's 32-bit slot. Then either advance to the next beat (ADDR) or go to DONE. A `xb_rvalid` arriving outside RESP is ignored.
- Read extraction for sub-word sizes: select the lane using addr[1:0] (byte) or addr[1] (half), then zero-extend to 64 bits.
- DONE: `ext_ack`=1 for exactly one cycle with final `ext_rdata`; then return to IDLE. IDLE never accepts in the same cycle as DONE.
- Timeout:
  - The counter increments every cycle in ADDR/RESP.
  - When it reaches `TIMEOUT_CYC`-1, go to DONE and set `err_timeout`.
  - On a timed-out read, `ext_rdata` = 64'hFFFF_FFFF_FFFF_FFFF.
  - On a timed-out write, the write is dropped.
- Upstream dropping `ext_req` mid-transaction does not abort. The bridge completes and still pulses `ext_ack`.

## Timing
- Reset values (synchronous, at first edge with `rst_n`=0): all outputs are 0, state is IDLE, counter is 0, and `err_timeout` is 0. A reset mid-transaction deasserts `xb_valid` at that edge without waiting for `xb_ready`.
- Best-case latency, measured from the edge sampling `ext_req` to the edge where `ext_ack` is high:
  - `ext_req` sampled at edge 0 → `xb_valid` high in cycle 1.
  - With `xb_ready`=1 and `xb_rvalid` in the next cycle: 1-beat access gives `ext_ack` in cycle 3.
  - 2-beat access gives `ext_ack` in cycle 5.
- `ext_rdata` holds its last value after `ext_ack` until the next DONE.
- `busy`=1 from cycle 1 through the DONE cycle inclusive.
- Every output is registered; there is no combinational path from `xb_*` inputs to `ext_*` outputs.

## Test plan
- Dword read at 0x100008: `xb_rdata` = 0x11223344, then 0x55667788.
  - Required: beats at 0x100008 and 0x10000C.
  - Required: `ext_rdata`=0x5566778811223344 and a single `ext_ack` pulse.
- Byte write 0xA5 at 0x200003:
  - Required: one beat at 0x200000, `xb_wstrb`=4'b1000, `xb_wdata`=0xA5A5A5A5.
- Half read at 0x300006 with `xb_rdata`=0xBEEF1234:
  - Required: `ext_rdata`=0x000000000000BEEF.
- Backpressure: `xb_ready` held low 5 cycles, `xb_rvalid` delayed 3 cycles.
  - Required: fields stay stable throughout; completes once; `ext_ack` high for exactly 1 cycle.
- Timeout with `TIMEOUT_CYC`=16 and no `xb_ready`:
  - Required: `ext_ack` after 16 cycles in ADDR/RESP, `ext_rdata` all-ones, `err_timeout`=1.
  - Then: the next normal transaction succeeds with `err_timeout` still 1.
- `rst_n` low during RESP of beat 0 of a dword write:
  - Required: all outputs 0 at the next edge, no `ext_ack`, FSM in IDLE.
  - Then: a new `ext_req` is accepted normally.
